// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x4 active-low keypad one column at a time and emits debounced key events.
// Latency: press accepted on the DEBOUNCE_SCANS-th agreeing sample (+2 cycles of row sync lag).
// Backpressure: none; KEY_VALID is a one-cycle pulse the consumer must take when it appears.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [3:0]    row_meta, row_s;
  logic [TW-1:0] tick;
  logic          sample;
  state_t        state, state_n;
  // The column stays frozen while a key is tracked, so col_idx doubles as the captured column.
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_cap, row_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    code_n;
  logic          valid_n, held_n;
  logic [1:0]    first_low;
  logic          cap_bit;

  assign sample  = (tick == TICK_LAST);
  assign cap_bit = row_s[row_cap];
  assign cnt_inc = cnt + CNT_ONE;

  assign COL = ~(4'b0001 << col_idx);

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= ROW;
      row_s    <= row_meta;
    end
  end

  // Free-running column dwell counter; wraps on the sample cycle.
  always_ff @(posedge CLK) begin
    if (RESET) tick <= '0;
    else if (sample) tick <= '0;
    else tick <= tick + TW'(1);
  end

  // Lowest-index active row wins when several rows are low in one column.
  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) first_low = 2'(i);
    end
  end

  // Scan/debounce state register and its data registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_SCAN;
      col_idx   <= 2'd0;
      row_cap   <= 2'd0;
      cnt       <= '0;
      KEY_CODE  <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      row_cap   <= row_n;
      cnt       <= cnt_n;
      KEY_CODE  <= code_n;
      KEY_VALID <= valid_n;
      KEY_HELD  <= held_n;
    end
  end

  // Next-state and output decisions, evaluated only on the sample cycle.
  always_comb begin
    state_n = state;
    col_n   = col_idx;
    row_n   = row_cap;
    cnt_n   = cnt;
    code_n  = KEY_CODE;
    valid_n = 1'b0;
    held_n  = KEY_HELD;
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (row_s == 4'hF) begin
            col_n = col_idx + 2'd1;
          end else begin
            row_n = first_low;
            cnt_n = CNT_ONE;
            if (CNT_ONE == DB_TARGET) begin
              state_n = ST_PRESSED;
              code_n  = {first_low, col_idx};
              valid_n = 1'b1;
              held_n  = 1'b1;
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!cap_bit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_n = ST_PRESSED;
              code_n  = {row_cap, col_idx};
              valid_n = 1'b1;
              held_n  = 1'b1;
            end
          end else begin
            state_n = ST_SCAN;
            col_n   = col_idx + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (cap_bit) begin
            cnt_n = CNT_ONE;
            if (CNT_ONE == DB_TARGET) begin
              state_n = ST_SCAN;
              held_n  = 1'b0;
              col_n   = col_idx + 2'd1;
            end else begin
              state_n = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (cap_bit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_n = ST_SCAN;
              held_n  = 1'b0;
              col_n   = col_idx + 2'd1;
            end
          end else begin
            // Release bounce: back to held, no new event.
            state_n = ST_PRESSED;
          end
        end
        default: state_n = ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model driven from COL, reference model checked every cycle.
// Directed scenarios first (idle, press, bounce, release bounce, multi-key, reset), then random keys.
module tb_keypad_scanner;
  localparam int ST = 4;
  localparam int DB = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_HELD;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .CLK(CLK), .RESET(RESET), .ROW(ROW), .COL(COL),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_HELD(KEY_HELD)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  logic [15:0] keys = 16'h0;

  // reference model: mode 0 scanning, 1 confirming press, 2 holding, 3 confirming release
  int         m_mode, m_col, m_trow, m_streak, m_phase;
  logic [3:0] m_code;
  logic       m_valid, m_held;
  logic [3:0] m_pipe[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // key k = 4*row + col closes row line to the column line when that column is driven low
  function automatic logic [3:0] phys_rows(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~|(k[4*i +: 4] & ~col);
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic [3:0] row_in);
    logic [3:0] seen;
    if (rst) begin
      m_mode = 0; m_col = 0; m_trow = 0; m_streak = 0; m_phase = 0;
      m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0;
      m_pipe = '{4'hF, 4'hF};
      return;
    end
    seen = m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(row_in);
    m_valid = 1'b0;
    if (m_phase == ST - 1) begin
      case (m_mode)
        0: if (seen == 4'hF) m_col = (m_col + 1) % 4;
           else begin
             for (int r = 3; r >= 0; r--) if (!seen[r]) m_trow = r;
             m_streak = 1; m_mode = 1;
           end
        1: if (!seen[m_trow]) m_streak++;
           else begin m_mode = 0; m_col = (m_col + 1) % 4; end
        2: if (seen[m_trow]) begin m_mode = 3; m_streak = 1; end
        default: if (seen[m_trow]) m_streak++; else m_mode = 2;
      endcase
      if (m_mode == 1 && m_streak >= DB) begin
        m_mode = 2; m_code = 4'(4 * m_trow + m_col); m_valid = 1'b1; m_held = 1'b1;
      end
      if (m_mode == 3 && m_streak >= DB) begin
        m_mode = 0; m_held = 1'b0; m_col = (m_col + 1) % 4;
      end
    end
    m_phase = (m_phase + 1) % ST;
  endtask

  task automatic cycle(input logic rst);
    logic [3:0] exp_col;
    RESET = rst;
    ROW   = phys_rows(keys, COL);
    model_step(rst, ROW);
    @(negedge CLK);
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    chk("col", COL, exp_col);
    chk("key_code", KEY_CODE, m_code);
    chk("key_valid", KEY_VALID, m_valid);
    chk("key_held", KEY_HELD, m_held);
    if (KEY_VALID === 1'b1) pulses++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic wait_held(input logic val, input int budget, input string tag);
    int n = 0;
    while (KEY_HELD !== val && n < budget) begin cycle(1'b0); n++; end
    chk(tag, KEY_HELD, val);
  endtask

  task automatic window(input logic [15:0] k);
    keys = k;
    run(ST);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_col"}, COL, 4'b1110);
    chk({tag, "_code"}, KEY_CODE, 4'd0);
    chk({tag, "_valid"}, KEY_VALID, 1'b0);
    chk({tag, "_held"}, KEY_HELD, 1'b0);
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    ROW   = 4'hF;
    cycle(1'b1);
    cycle(1'b1);
    check_reset_vals("rst");

    // idle scan
    keys = 16'h0; pulses = 0;
    run(40);
    chk("idle_pulses", pulses, 0);

    // press row 2 / col 1
    keys = 16'h1 << 9; pulses = 0;
    wait_held(1'b1, 100, "press9_held");
    run(20);
    chk("press9_pulses", pulses, 1);
    chk("press9_code", KEY_CODE, 4'd9);
    chk("press9_col", COL, 4'b1101);
    keys = 16'h0;
    wait_held(1'b0, 100, "rel9_held");
    chk("rel9_pulses", pulses, 1);

    // press bounce: key seen by exactly one sample on col 1
    n = 0;
    while (COL !== 4'b1101 && n < 100) begin cycle(1'b0); n++; end
    chk("bounce_reach_col1", COL, 4'b1101);
    pulses = 0;
    window(16'h1 << 9);
    window(16'h0);
    chk("bounce_col", COL, 4'b1011);
    run(10);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_code", KEY_CODE, 4'd9);

    // release with bounce
    keys = 16'h1 << 9;
    wait_held(1'b1, 100, "relb_held");
    n = 0;
    while (m_phase != 0 && n < ST) begin cycle(1'b0); n++; end
    pulses = 0;
    window(16'h0);        chk("relb_h1", KEY_HELD, 1'b1);
    window(16'h1 << 9);   chk("relb_bounce", KEY_HELD, 1'b1);
    window(16'h0);        chk("relb_h2", KEY_HELD, 1'b1);
    window(16'h0);        chk("relb_h3", KEY_HELD, 1'b1);
    window(16'h0);        chk("relb_done", KEY_HELD, 1'b0);
    chk("relb_pulses", pulses, 0);

    // two keys in col 0, then a second key while held
    keys = (16'h1 << 4) | (16'h1 << 12);
    wait_held(1'b1, 100, "two_held");
    chk("two_code", KEY_CODE, 4'd4);
    pulses = 0;
    keys = keys | (16'h1 << 3);
    run(40);
    chk("two_extra_pulses", pulses, 0);
    chk("two_extra_code", KEY_CODE, 4'd4);
    keys = 16'h0;
    wait_held(1'b0, 100, "two_release");

    // reset while confirming a press
    keys = 16'h1 << 6;
    n = 0;
    while (m_mode != 1 && n < 100) begin cycle(1'b0); n++; end
    chk("reach_debounce", m_mode, 1);
    pulses = 0;
    cycle(1'b1);
    check_reset_vals("rst_deb");
    keys = 16'h0;
    run(12);
    chk("rst_deb_pulses", pulses, 0);

    // reset while held
    keys = 16'h1 << 6;
    wait_held(1'b1, 100, "rst_prs_held");
    pulses = 0;
    cycle(1'b1);
    check_reset_vals("rst_prs");
    keys = 16'h0;
    run(20);
    chk("rst_prs_pulses", pulses, 0);

    // random key activity with occasional resets
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: keys = 16'h0;
        1: keys = 16'h1 << $urandom_range(0, 15);
        2: keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      n = $urandom_range(1, 40);
      for (int c = 0; c < n; c++) cycle($urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
